// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map and STATUS bit layout shared by mem_responder.
//   MMIO window   : adr[31:16] == MMIO_BASE.
//   Register offsets are byte offsets inside that window.
//   decode_mmio() turns an offset into a register select.
package mem_map_pkg;

  localparam logic [15:0] MMIO_BASE    = 16'hFFFF;
  localparam logic [15:0] RX_DATA_OFS  = 16'h0000;
  localparam logic [15:0] TX_DATA_OFS  = 16'h0004;
  localparam logic [15:0] STATUS_OFS   = 16'h0008;
  localparam logic [15:0] CYCLE_LO_OFS = 16'h000C;
  localparam logic [15:0] CYCLE_HI_OFS = 16'h0010;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_RX_OVERRUN  = 2;
  localparam int ST_RX_UNDERRUN = 3;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RX_DATA,
    REG_TX_DATA,
    REG_STATUS,
    REG_CYCLE_LO,
    REG_CYCLE_HI
  } mmio_reg_e;

  function automatic mmio_reg_e decode_mmio(input logic [15:0] ofs);
    mmio_reg_e sel;
    sel = REG_NONE;
    case (ofs)
      RX_DATA_OFS:  sel = REG_RX_DATA;
      TX_DATA_OFS:  sel = REG_TX_DATA;
      STATUS_OFS:   sel = REG_STATUS;
      CYCLE_LO_OFS: sel = REG_CYCLE_LO;
      CYCLE_HI_OFS: sel = REG_CYCLE_HI;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two (>= 2).
// Ports:
//   clk, rstn         clock, asynchronous active-low reset (empties FIFO)
//   push_i, data_i    write request and data
//   pop_i             read request (removes data_o)
//   data_o            current head entry (meaningless when empty)
//   full_o, empty_o   occupancy flags
// A push while full is accepted only if a pop happens in the same cycle,
// which frees the slot the push lands in. Pops on empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-port responder for the multicycle core.
//   Word RAM (2^ADDR_W x 32) plus an MMIO window at 0xFFFF_xxxx that
//   buffers UART bytes through an RX and a TX FIFO.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   adr, writedata            byte address and store data from the core
//   memwrite, memread         one-cycle strobes; memread gates pop side effects
//   readdata                  registered read data (latency 1, every cycle)
//   tx_data, tx_valid, tx_ready  byte stream to the UART transmitter
//   rx_data, rx_valid         byte pulses from the UART receiver
// TX handshake: tx_valid is high whenever the TX FIFO holds a byte and
// tx_data shows that byte; it is consumed on a cycle where tx_valid and
// tx_ready are both high. tx_data reads 0 whenever tx_valid is low.
// Optional build macro CYCLE_COUNTER_EN adds a 64-bit cycle counter at
// FFFF_000C (low word, snapshots high) and FFFF_0010 (snapshot).
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int TXQ_DEPTH = 16,
  parameter int RXQ_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  logic [31:0] ram_q [2**ADDR_W];
  logic [ADDR_W-1:0] ram_idx;
  logic        is_mmio;
  mmio_reg_e   reg_sel;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] status_w;
  logic        overrun_q, overrun_d;
  logic        underrun_q, underrun_d;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_head;
  logic        rx_rd, status_wr;
  logic        unused_adr;

  // Low address bits and bits above the RAM index are don't-care (aliasing).
  assign unused_adr = ^adr;
  assign ram_idx    = adr[ADDR_W+1:2];
  assign is_mmio    = (adr[31:16] == MMIO_BASE);
  assign reg_sel    = is_mmio ? decode_mmio({adr[15:2], 2'b00}) : REG_NONE;

  assign rx_rd     = memread && (reg_sel == REG_RX_DATA);
  assign rx_pop    = rx_rd && !rx_empty;
  // A full RX FIFO still accepts a byte if the core pops in the same cycle.
  assign rx_push   = rx_valid;
  assign tx_push   = memwrite && (reg_sel == REG_TX_DATA);
  assign tx_pop    = tx_valid && tx_ready;
  assign status_wr = memwrite && (reg_sel == REG_STATUS);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;
  assign readdata = readdata_q;

  sync_fifo #(.WIDTH(8), .DEPTH(RXQ_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn),
    .push_i(rx_push), .data_i(rx_data), .pop_i(rx_pop),
    .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TXQ_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn),
    .push_i(tx_push), .data_i(writedata[7:0]), .pop_i(tx_pop),
    .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  always_ff @(posedge clk) begin
    if (memwrite && !is_mmio) ram_q[ram_idx] <= writedata;
  end

`ifdef CYCLE_COUNTER_EN
  logic [63:0] cycle_q;
  logic [31:0] cycle_hi_snap_q;

  // High word is captured when the low word is read, so a low-word carry
  // between the two reads cannot tear the 64-bit value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_q         <= '0;
      cycle_hi_snap_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (memread && (reg_sel == REG_CYCLE_LO)) cycle_hi_snap_q <= cycle_q[63:32];
    end
  end
`endif

  always_comb begin
    status_w = '0;
    status_w[ST_RX_NONEMPTY] = !rx_empty;
    status_w[ST_TX_FULL]     = tx_full;
    status_w[ST_RX_OVERRUN]  = overrun_q;
    status_w[ST_RX_UNDERRUN] = underrun_q;
  end

  always_comb begin
    readdata_d = '0;
    if (!is_mmio) begin
      readdata_d = ram_q[ram_idx];
    end else begin
      case (reg_sel)
        REG_RX_DATA:  readdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        REG_STATUS:   readdata_d = status_w;
`ifdef CYCLE_COUNTER_EN
        REG_CYCLE_LO: readdata_d = cycle_q[31:0];
        REG_CYCLE_HI: readdata_d = cycle_hi_snap_q;
`endif
        default:      readdata_d = '0;
      endcase
    end
  end

  // A STATUS write clears the sticky bits; a new event in the same cycle wins.
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (status_wr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (rx_valid && rx_full && !rx_pop) overrun_d = 1'b1;
    if (rx_rd && rx_empty)              underrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      readdata_q <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
module tb_mem_responder;

  localparam logic [31:0] A_RX   = 32'hFFFF_0000;
  localparam logic [31:0] A_TX   = 32'hFFFF_0004;
  localparam logic [31:0] A_ST   = 32'hFFFF_0008;
  localparam logic [31:0] A_CLO  = 32'hFFFF_000C;
  localparam logic [31:0] A_CHI  = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] adr, writedata, readdata;
  logic        memwrite, memread;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;

  int checks = 0;
  int errors = 0;
  longint tb_cyc;

  // Clock / reset block
  always #5 clk = ~clk;

  // Cycles since reset release: the counter sees one increment per edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  mem_responder dut (
    .clk(clk), .rstn(rstn),
    .adr(adr), .writedata(writedata),
    .memwrite(memwrite), .memread(memread),
    .readdata(readdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    adr = a; writedata = d; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic pop, output logic [31:0] d);
    adr = a; memread = pop;
    tick();
    memread = 1'b0;
    d = readdata;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    logic [31:0] d;
    adr = 32'h0; writedata = 32'h0; memwrite = 0; memread = 0;
    tx_ready = 0; rx_data = 8'h0; rx_valid = 0;
    rstn = 1'b0;
    #1;
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    bus_write(32'h0000_0040, 32'hDEAD_BEEF);
    bus_write(32'h0000_0044, 32'h1234_5678);
    bus_read(32'h0000_0040, 1'b0, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read40: got %h expected %h", d, 32'hDEAD_BEEF); end
    bus_read(32'h0001_0040, 1'b0, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias: got %h expected %h", d, 32'hDEAD_BEEF); end
    bus_read(32'h0000_0047, 1'b0, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_read44: got %h expected %h", d, 32'h1234_5678); end
    // Write then hold the address: new value one edge later.
    bus_write(32'h0000_0048, 32'hCAFE_0001);
    tick();
    checks++; if (readdata !== 32'hCAFE_0001) begin errors++; $display("FAIL ram_wr_visible: got %h expected %h", readdata, 32'hCAFE_0001); end
  endtask

  task automatic test_mmio_misc();
    logic [31:0] d;
    bus_write(32'hFFFF_0040, 32'h0BAD_0BAD);
    bus_read(32'h0000_0040, 1'b0, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mmio_no_ram_write: got %h expected %h", d, 32'hDEAD_BEEF); end
    bus_read(32'hFFFF_0020, 1'b1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mmio_unmapped: got %h expected %h", d, 32'h0); end
    bus_read(A_TX, 1'b1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mmio_tx_read: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    logic [7:0]  exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    for (int i = 0; i < 3; i++) rx_push(exp_b[i]);
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rx_status_ne: got %h expected %h", d, 32'h1); end
    for (int i = 0; i < 3; i++) begin
      bus_read(A_RX, 1'b1, d);
      checks++; if (d !== {24'h0, exp_b[i]}) begin errors++; $display("FAIL rx_pop%0d: got %h expected %h", i, d, {24'h0, exp_b[i]}); end
    end
    bus_read(A_RX, 1'b1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_pop_empty: got %h expected %h", d, 32'h0); end
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL rx_underrun: got %h expected %h", d, 32'h8); end
    bus_write(A_ST, 32'h0);
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_status_clear: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 15; i++) bus_write(A_TX, 32'hFFFF_FF00 | i);
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx_not_full15: got %h expected %h", d, 32'h0); end
    bus_write(A_TX, 32'd15);
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL tx_full16: got %h expected %h", d, 32'h2); end
    bus_write(A_TX, 32'd16);
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL tx_full17: got %h expected %h", d, 32'h2); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin errors++; $display("FAIL tx_drain%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, 8'(i)); end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 16; i++) rx_push(8'h10 + 8'(i));
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL full_status: got %h expected %h", d, 32'h1); end
    rx_push(8'h55);
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL full_overrun: got %h expected %h", d, 32'h5); end
    bus_read(A_RX, 1'b0, d);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL full_head: got %h expected %h", d, 32'h10); end
    // Pop and receive in the same cycle on a full FIFO.
    adr = A_RX; memread = 1'b1; rx_data = 8'h55; rx_valid = 1'b1;
    tick();
    memread = 1'b0; rx_valid = 1'b0;
    checks++; if (readdata !== 32'h10) begin errors++; $display("FAIL full_pushpop: got %h expected %h", readdata, 32'h10); end
    for (int i = 1; i < 16; i++) begin
      bus_read(A_RX, 1'b1, d);
      checks++; if (d !== 32'h10 + i) begin errors++; $display("FAIL full_drain%0d: got %h expected %h", i, d, 32'h10 + i); end
    end
    bus_read(A_RX, 1'b1, d);
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL full_tail: got %h expected %h", d, 32'h55); end
    bus_read(A_RX, 1'b1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL full_empty: got %h expected %h", d, 32'h0); end
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'hC) begin errors++; $display("FAIL full_sticky: got %h expected %h", d, 32'hC); end
    bus_write(A_ST, 32'hFFFF_FFFF);
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL full_clear: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(A_TX, 32'hA0 + i);
    rx_push(8'h77);
    tx_ready = 1'b1;
    tick();
    checks++; if (tx_data !== 8'hA1) begin errors++; $display("FAIL mid_drain: got %h expected %h", tx_data, 8'hA1); end
    adr = 32'h0000_0040;
    tick();
    checks++; if (readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_pre_reset: got %h expected %h", readdata, 32'hDEAD_BEEF); end
    rstn = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL mid_readdata: got %h expected %h", readdata, 32'h0); end
    tx_ready = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid: got %b expected 0", tx_valid); end
    bus_read(A_ST, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_after_status: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] d;
    longint      exp_lo;
`ifdef CYCLE_COUNTER_EN
    bus_read(A_CLO, 1'b1, d);
    exp_lo = tb_cyc - 1;
    checks++; if (d !== exp_lo[31:0]) begin errors++; $display("FAIL cyc_lo: got %h expected %h", d, exp_lo[31:0]); end
    bus_read(A_CHI, 1'b1, d);
    checks++; if (d !== exp_lo[63:32]) begin errors++; $display("FAIL cyc_hi: got %h expected %h", d, exp_lo[63:32]); end
    bus_read(A_CLO, 1'b0, d);
    exp_lo = tb_cyc - 1;
    checks++; if (d !== exp_lo[31:0]) begin errors++; $display("FAIL cyc_lo2: got %h expected %h", d, exp_lo[31:0]); end
`else
    exp_lo = 0;
    bus_read(A_CLO, 1'b1, d);
    checks++; if (d !== exp_lo[31:0]) begin errors++; $display("FAIL cyc_lo_off: got %h expected %h", d, exp_lo[31:0]); end
    bus_read(A_CHI, 1'b1, d);
    checks++; if (d !== exp_lo[31:0]) begin errors++; $display("FAIL cyc_hi_off: got %h expected %h", d, exp_lo[31:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_ram();
    test_mmio_misc();
    test_rx();
    test_tx();
    test_back_to_back();
    test_reset_mid();
    test_cycle_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
